// File: rtl/lsu_dcache_fill_ctl_pkg.sv
// Shared definitions for the D-cache fill controller.
// Holds the fill FSM encoding, dcache geometry constants and the way-index width.
package lsu_dcache_fill_ctl_pkg;

    localparam int DC_NWAY = 4;  // associativity; tied to the 2-bit LFSR output
    localparam int DC_IDXW = 7;  // 8KB, 16B lines, 4-way -> 128 sets
    localparam int DC_WAYW = 2;  // way-index width

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOOKUP = 2'b01,
        FILL   = 2'b10
    } fill_state_t;

endpackage

// File: rtl/lsu_dcache_way_pick.sv
// Replacement-way selection for a D-cache fill (purely combinational).
// Ports:
//   vld      in  DC_NWAY  valid bits of the indexed set
//   lock     in  DC_NWAY  locked ways (all-ones means "ignore locks")
//   lfsr_way in  DC_WAYW  pseudo-random way from the dcache LFSR
//   way      out DC_WAYW  chosen way
//   use_rand out 1        no usable invalid way; the random path was taken
module lsu_dcache_way_pick
    import lsu_dcache_fill_ctl_pkg::*;
(
    input  logic [DC_NWAY-1:0] vld,
    input  logic [DC_NWAY-1:0] lock,
    input  logic [DC_WAYW-1:0] lfsr_way,
    output logic [DC_WAYW-1:0] way,
    output logic               use_rand
);

    logic [DC_NWAY-1:0] eff_lock;
    logic [DC_NWAY-1:0] avail;
    logic [DC_WAYW-1:0] cand;

    always_comb begin
        // A fully locked set would leave nothing to replace, so locks are dropped.
        eff_lock = (&lock) ? '0 : lock;
        avail    = ~vld & ~eff_lock;
        way      = lfsr_way;
        use_rand = 1'b1;
        cand     = '0;
        // Scan downward so the lowest-numbered available way is the one kept.
        for (int w = DC_NWAY - 1; w >= 0; w--) begin
            if (avail[w]) begin
                way      = DC_WAYW'(w);
                use_rand = 1'b0;
            end
        end
        if (use_rand) begin
            // Nearest unlocked way at or above lfsr_way, wrapping 3->0.
            for (int k = DC_NWAY - 1; k >= 0; k--) begin
                cand = lfsr_way + DC_WAYW'(k);
                if (!eff_lock[cand]) way = cand;
            end
        end
    end

endmodule

// File: rtl/lsu_dcache_fill_ctl.sv
// D-cache line-fill sequencer: round-robin arbitration of per-thread fill
// requests, valid-array lookup, replacement-way choice and a single fill-write
// command to the data/tag arrays. One fill in flight at a time.
// Optional feature macro: LSU_DCACHE_WAY_LOCK_EN (honour way_lock_mask).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   fill_req/fill_idx/fill_gnt       per-thread request, set index, 1-cycle grant
//   vld_rd_en/vld_rd_idx/vld_rd_data valid-array read (data 1 cycle after strobe)
//   lfsr_way/lfsr_advance            random way input, LFSR step pulse
//   way_lock_mask                    locked ways (feature build only)
//   fill_wr_vld/way/idx/tid/ack      fill-write command and its acceptance
//   busy                             fill in LOOKUP or FILL
module lsu_dcache_fill_ctl
    import lsu_dcache_fill_ctl_pkg::*;
#(
    parameter int NTHR = 4,
    parameter int NWAY = DC_NWAY,
    parameter int IDXW = DC_IDXW,
    parameter int TIDW = (NTHR > 1) ? $clog2(NTHR) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NTHR-1:0]      fill_req,
    input  logic [NTHR*IDXW-1:0] fill_idx,
    output logic [NTHR-1:0]      fill_gnt,
    output logic                 vld_rd_en,
    output logic [IDXW-1:0]      vld_rd_idx,
    input  logic [NWAY-1:0]      vld_rd_data,
    input  logic [DC_WAYW-1:0]   lfsr_way,
    output logic                 lfsr_advance,
    input  logic [NWAY-1:0]      way_lock_mask,
    output logic                 fill_wr_vld,
    output logic [DC_WAYW-1:0]   fill_wr_way,
    output logic [IDXW-1:0]      fill_wr_idx,
    output logic [TIDW-1:0]      fill_wr_tid,
    input  logic                 fill_wr_ack,
    output logic                 busy
);

    fill_state_t         state;
    logic [TIDW-1:0]     rr_ptr;
    logic [TIDW-1:0]     win;
    logic [TIDW-1:0]     cand;
    logic                req_any;
    logic                grant;
    logic [NWAY-1:0]     lock;
    logic [DC_WAYW-1:0]  pick_way;
    logic                pick_rand;

`ifdef LSU_DCACHE_WAY_LOCK_EN
    assign lock = way_lock_mask;
`else
    logic unused_lock;
    assign lock        = '0;
    assign unused_lock = |way_lock_mask;
`endif

    // Round-robin: downward scan so the smallest offset from rr_ptr wins.
    always_comb begin
        win     = '0;
        cand    = '0;
        req_any = 1'b0;
        for (int i = NTHR - 1; i >= 0; i--) begin
            cand = rr_ptr + TIDW'(i);
            if (fill_req[cand]) begin
                win     = cand;
                req_any = 1'b1;
            end
        end
    end

    // Grant and valid-array read are combinational from IDLE; reset masks them.
    assign grant        = (state == IDLE) && req_any && !reset;
    assign fill_gnt     = grant ? (NTHR'(1) << win) : '0;
    assign vld_rd_en    = grant;
    assign vld_rd_idx   = grant ? fill_idx[win*IDXW +: IDXW] : '0;
    assign lfsr_advance = (state == LOOKUP) && pick_rand && !reset;

    lsu_dcache_way_pick u_way_pick (
        .vld      (vld_rd_data),
        .lock     (lock),
        .lfsr_way (lfsr_way),
        .way      (pick_way),
        .use_rand (pick_rand)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            fill_wr_vld <= 1'b0;
            fill_wr_way <= '0;
            fill_wr_idx <= '0;
            fill_wr_tid <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        fill_wr_tid <= win;
                        fill_wr_idx <= fill_idx[win*IDXW +: IDXW];
                        busy        <= 1'b1;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    fill_wr_way <= pick_way;
                    fill_wr_vld <= 1'b1;
                    state       <= FILL;
                end
                FILL: begin
                    if (fill_wr_ack) begin
                        fill_wr_vld <= 1'b0;
                        busy        <= 1'b0;
                        rr_ptr      <= fill_wr_tid + TIDW'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dcache_fill_ctl.sv
module tb_lsu_dcache_fill_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fill_req;
    logic [27:0] fill_idx;
    logic [3:0]  fill_gnt;
    logic        vld_rd_en;
    logic [6:0]  vld_rd_idx;
    logic [3:0]  vld_rd_data;
    logic [1:0]  lfsr_way;
    logic        lfsr_advance;
    logic [3:0]  way_lock_mask;
    logic        fill_wr_vld;
    logic [1:0]  fill_wr_way;
    logic [6:0]  fill_wr_idx;
    logic [1:0]  fill_wr_tid;
    logic        fill_wr_ack;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int rr    = 0;   // model round-robin pointer

    always #5 clk = ~clk;

    lsu_dcache_fill_ctl dut (
        .clk           (clk),
        .reset         (reset),
        .fill_req      (fill_req),
        .fill_idx      (fill_idx),
        .fill_gnt      (fill_gnt),
        .vld_rd_en     (vld_rd_en),
        .vld_rd_idx    (vld_rd_idx),
        .vld_rd_data   (vld_rd_data),
        .lfsr_way      (lfsr_way),
        .lfsr_advance  (lfsr_advance),
        .way_lock_mask (way_lock_mask),
        .fill_wr_vld   (fill_wr_vld),
        .fill_wr_way   (fill_wr_way),
        .fill_wr_idx   (fill_wr_idx),
        .fill_wr_tid   (fill_wr_tid),
        .fill_wr_ack   (fill_wr_ack),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First requesting thread scanning rr, rr+1, ... modulo 4.
    function automatic int model_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Replacement rule: lowest invalid unlocked way, else lfsr_way moved up to
    // the next unlocked way; a fully locked set behaves as unlocked.
    function automatic int model_way(input logic [3:0] v, input logic [3:0] lk_in,
                                     input int l, output bit rnd);
        logic [3:0] lk;
`ifdef LSU_DCACHE_WAY_LOCK_EN
        lk = (lk_in == 4'hF) ? 4'h0 : lk_in;
`else
        lk = 4'h0 | (lk_in & 4'h0);
`endif
        for (int w = 0; w < 4; w++) begin
            if (!v[w] && !lk[w]) begin
                rnd = 1'b0;
                return w;
            end
        end
        rnd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (!lk[(l + k) % 4]) return (l + k) % 4;
        end
        return l;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"},  fill_gnt, 0);
        chk({tag, "_rden"}, vld_rd_en, 0);
        chk({tag, "_ridx"}, vld_rd_idx, 0);
        chk({tag, "_adv"},  lfsr_advance, 0);
        chk({tag, "_wvld"}, fill_wr_vld, 0);
        chk({tag, "_wway"}, fill_wr_way, 0);
        chk({tag, "_widx"}, fill_wr_idx, 0);
        chk({tag, "_wtid"}, fill_wr_tid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One complete fill starting in IDLE; returns in IDLE with fill_req=0.
    task automatic do_fill(input logic [3:0] mask, input logic [27:0] idxs,
                           input logic [3:0] v, input logic [1:0] l,
                           input logic [3:0] lk, input int hold);
        int w, ew;
        bit er;
        logic [6:0] eidx;
        w    = model_pick(mask, rr);
        eidx = idxs[w*7 +: 7];
        fill_req    = mask;
        fill_idx    = idxs;
        fill_wr_ack = 1'b0;
        #1;
        chk("grant", fill_gnt, 32'd1 << w);
        chk("rd_en", vld_rd_en, 1);
        chk("rd_idx", vld_rd_idx, eidx);
        chk("busy_idle", busy, 0);
        step();
        // LOOKUP: request changes must not matter; valid data arrives now.
        fill_req      = 4'($urandom);
        fill_idx      = 28'($urandom);
        vld_rd_data   = v;
        lfsr_way      = l;
        way_lock_mask = lk;
        #1;
        ew = model_way(v, lk, int'(l), er);
        chk("gnt_lookup", fill_gnt, 0);
        chk("adv_lookup", lfsr_advance, er);
        chk("busy_lookup", busy, 1);
        chk("wvld_lookup", fill_wr_vld, 0);
        step();
        vld_rd_data   = 4'($urandom);
        lfsr_way      = 2'($urandom);
        way_lock_mask = 4'($urandom);
        for (int c = 0; c <= hold; c++) begin
            fill_req    = 4'($urandom);
            fill_wr_ack = (c == hold);
            #1;
            chk("wr_vld", fill_wr_vld, 1);
            chk("wr_way", fill_wr_way, ew);
            chk("wr_idx", fill_wr_idx, eidx);
            chk("wr_tid", fill_wr_tid, w);
            chk("gnt_fill", fill_gnt, 0);
            chk("adv_fill", lfsr_advance, 0);
            chk("busy_fill", busy, 1);
            step();
        end
        fill_wr_ack = 1'b0;
        fill_req    = 4'h0;
        #1;
        chk("wvld_after", fill_wr_vld, 0);
        chk("busy_after", busy, 0);
        rr = (w + 1) % 4;
    endtask

    initial begin
        logic [3:0] m;
        reset         = 1'b1;
        fill_req      = 4'h0;
        fill_idx      = '0;
        vld_rd_data   = 4'h0;
        lfsr_way      = 2'd0;
        way_lock_mask = 4'h0;
        fill_wr_ack   = 1'b0;
        step();
        fill_req = 4'hF;   // reset must mask the grant
        step();
        #1;
        check_idle_outputs("reset");
        reset    = 1'b0;
        fill_req = 4'h0;
        rr       = 0;
        step();

        // Directed: invalid-way path, then random path.
        do_fill(4'b0001, 28'h15, 4'b1011, 2'd1, 4'h0, 0);
        do_fill(4'b0001, 28'h2A, 4'b1111, 2'd3, 4'h0, 0);

        // All threads requesting with immediate acks: round-robin order.
        for (int n = 0; n < 5; n++)
            do_fill(4'b1111, 28'($urandom), 4'($urandom), 2'($urandom), 4'h0, 0);

        // Long ack stall.
        do_fill(4'b0110, 28'($urandom), 4'b1111, 2'd2, 4'h0, 10);

        // Ack outside FILL is ignored.
        fill_wr_ack = 1'b1;
        #1;
        chk("idle_ack_gnt", fill_gnt, 0);
        step();
        fill_wr_ack = 1'b0;
        #1;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_wvld", fill_wr_vld, 0);

        // Reset during FILL, then a late ack.
        fill_req = 4'b0100;
        fill_idx = 28'($urandom);
        step();
        vld_rd_data = 4'b0111;
        step();
        #1;
        chk("pre_reset_wvld", fill_wr_vld, 1);
        fill_req = 4'h0;
        reset    = 1'b1;
        step();
        reset       = 1'b0;
        fill_wr_ack = 1'b1;
        #1;
        check_idle_outputs("midfill_reset");
        step();
        fill_wr_ack = 1'b0;
        #1;
        chk("late_ack_wvld", fill_wr_vld, 0);
        chk("late_ack_busy", busy, 0);
        rr = 0;
        do_fill(4'b1010, 28'($urandom), 4'b1110, 2'd0, 4'h0, 1);

`ifdef LSU_DCACHE_WAY_LOCK_EN
        do_fill(4'b0001, 28'h11, 4'b1111, 2'd3, 4'b1000, 0);
        do_fill(4'b0001, 28'h12, 4'b1111, 2'd1, 4'b1111, 0);
`endif

        // Randomized fills against the model.
        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom);
            if (m == 4'h0) m = 4'b1000;
            do_fill(m, 28'($urandom),
                    ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom),
                    2'($urandom), 4'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
